// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: framebuffer read port plus timed video output of the VGA timing generator
interface vga_timing_gen_if #(
  parameter int ADDR_W = 19,
  parameter int WIDTH  = 12
);
  logic [ADDR_W-1:0] address;
  logic [31:0]       data;
  logic [WIDTH-1:0]  hdata;
  logic [WIDTH-1:0]  vdata;
  logic              hsync;
  logic              vsync;
  logic              data_enable;
  logic              frame_start;
  logic              line_start;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  modport master (
    output address, hdata, vdata, hsync, vsync, data_enable, frame_start, line_start, red, green, blue,
    input  data
  );
  modport slave (
    input  address, hdata, vdata, hsync, vsync, data_enable, frame_start, line_start, red, green, blue,
    output data
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA h/v timing with framebuffer addressing and latency-matched video outputs
// Optional colour-bar source with test_mode port: define VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int   WIDTH   = 12,
  parameter int   HSIZE   = 800,
  parameter int   HFP     = 856,
  parameter int   HSP     = 976,
  parameter int   HMAX    = 1040,
  parameter int   VSIZE   = 600,
  parameter int   VFP     = 637,
  parameter int   VSP     = 643,
  parameter int   VMAX    = 666,
  parameter logic HSPP    = 1'b1,
  parameter logic VSPP    = 1'b1,
  parameter int   ADDR_W  = 19,
  parameter int   LATENCY = 2,
  parameter int   SCALE   = 0
) (
  input logic clk,
  input logic rst_n,
  input logic en,
`ifdef VGA_TEST_PATTERN_EN
  input logic test_mode,
`endif
  vga_timing_gen_if.master bus
);
  typedef struct packed {
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] v;
    logic             hs;
    logic             vs;
    logic             de;
    logic             fs;
    logic             ls;
  } pix_t;
  localparam pix_t IDLE = '{h: '0, v: '0, hs: !HSPP, vs: !VSPP, de: 1'b0, fs: 1'b0, ls: 1'b0};
  localparam logic [WIDTH-1:0]  SMASK = WIDTH'((1 << SCALE) - 1);
  localparam logic [ADDR_W-1:0] LSTEP = ADDR_W'(HSIZE >> SCALE);
  logic [WIDTH-1:0]  h, v, h_n, v_n;
  logic [ADDR_W-1:0] base, base_n, addr;
  logic              h_wrap, f_wrap;
  pix_t              cur, q;
  pix_t              pipe [LATENCY];
  logic [23:0]       pix, rgb;
  logic              unused_hi;
  // base tracks (v>>SCALE)*(HSIZE>>SCALE) by adding one scaled line width per source line
  always_comb begin
    h_wrap = h == WIDTH'(HMAX - 1);
    f_wrap = h_wrap && v == WIDTH'(VMAX - 1);
    h_n    = (!en || h_wrap) ? '0 : h + WIDTH'(1);
    v_n    = (!en || f_wrap) ? '0 : h_wrap ? v + WIDTH'(1) : v;
    base_n = (!en || f_wrap) ? '0 : (h_wrap && (v & SMASK) == SMASK) ? base + LSTEP : base;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h    <= '0;
      v    <= '0;
      base <= '0;
      addr <= '0;
    end else begin
      h    <= h_n;
      v    <= v_n;
      base <= base_n;
      addr <= (h_n < WIDTH'(HSIZE) && v_n < WIDTH'(VSIZE)) ? base_n + ADDR_W'(h_n >> SCALE) : '0;
    end
  always_comb
    cur = en ? pix_t'{h: h, v: v,
                      hs: (h >= WIDTH'(HFP) && h < WIDTH'(HSP)) ? HSPP : !HSPP,
                      vs: (v >= WIDTH'(VFP) && v < WIDTH'(VSP)) ? VSPP : !VSPP,
                      de: h < WIDTH'(HSIZE) && v < WIDTH'(VSIZE),
                      fs: h == '0 && v == '0,
                      ls: h == '0} : IDLE;
  // Position/sync ride a LATENCY-deep shift so they line up with the returning pixel word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= IDLE;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  assign q = pipe[LATENCY-1];
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  bar;
  logic [31:0] hx;
  // bar = hdata*8/HSIZE, found by comparing against the seven bar boundaries
  always_comb begin
    hx  = 32'(q.h) << 3;
    bar = '0;
    for (int k = 1; k < 8; k++) bar = bar + ((hx >= 32'(k * HSIZE)) ? 3'd1 : 3'd0);
    pix = test_mode ? {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}} : bus.data[23:0];
  end
`else
  assign pix = bus.data[23:0];
`endif
  assign rgb             = q.de ? pix : '0;
  assign unused_hi       = ^bus.data[31:24];
  assign bus.address     = addr;
  assign bus.hdata       = q.h;
  assign bus.vdata       = q.v;
  assign bus.hsync       = q.hs;
  assign bus.vsync       = q.vs;
  assign bus.data_enable = q.de;
  assign bus.frame_start = q.fs;
  assign bus.line_start  = q.ls;
  assign {bus.red, bus.green, bus.blue} = rgb;
endmodule
